// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : MIPS instruction-fetch stage with PC, IF/ID register and a
//            direct-mapped BTB of 2-bit counters; counts EX redirects.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] EXC_VECTOR  = 32'hF0000000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] StartPC,
    input  logic        Stall,
    input  logic        Exception,
    input  logic        ExRedirect,
    input  logic [31:0] ExRedirectPC,
    input  logic        ExBranchValid,
    input  logic [31:0] ExBranchPC,
    input  logic        ExBranchTaken,
    input  logic [31:0] ExBranchTarget,
    output logic [31:0] IMemAddress,
    input  logic [31:0] IMemData,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PC4,
    output logic        IFID_Valid,
    output logic        IFID_PredTaken,
    output logic [31:0] IFID_PredTarget,
    output logic [31:0] RedirectCount
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDX;

    logic [31:0]     pc_q, pc_d;
    logic [31:0]     ifid_instr_q, ifid_pc4_q, ifid_tgt_q, redir_cnt_q;
    logic            ifid_valid_q, ifid_pt_q;

    logic            btb_valid_q [BTB_ENTRIES];
    logic [1:0]      btb_cnt_q   [BTB_ENTRIES];
    logic [TAGW-1:0] btb_tag_q   [BTB_ENTRIES];
    logic [31:0]     btb_tgt_q   [BTB_ENTRIES];

    logic [IDX-1:0]  w_lk_idx, w_up_idx;
    logic [TAGW-1:0] w_lk_tag, w_up_tag;
    logic            w_lk_hit, w_up_hit, w_pred_taken;
    logic [31:0]     w_pc4, w_pred_next;
    logic [1:0]      w_unused_bits;

    assign w_lk_idx      = pc_q[IDX+1:2];
    assign w_lk_tag      = pc_q[31:IDX+2];
    assign w_up_idx      = ExBranchPC[IDX+1:2];
    assign w_up_tag      = ExBranchPC[31:IDX+2];
    assign w_unused_bits = ExBranchPC[1:0];

    assign w_lk_hit     = btb_valid_q[w_lk_idx] && (btb_tag_q[w_lk_idx] == w_lk_tag);
    assign w_up_hit     = btb_valid_q[w_up_idx] && (btb_tag_q[w_up_idx] == w_up_tag);
    assign w_pred_taken = w_lk_hit && btb_cnt_q[w_lk_idx][1];
    assign w_pc4        = pc_q + 32'd4;
    assign w_pred_next  = w_pred_taken ? btb_tgt_q[w_lk_idx] : w_pc4;

    always_comb begin
        pc_d = w_pred_next;
        if (Exception)       pc_d = EXC_VECTOR;
        else if (ExRedirect) pc_d = ExRedirectPC;
        else if (Stall)      pc_d = pc_q;
    end

    // PC, IF/ID and redirect counter
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q         <= StartPC;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pt_q    <= 1'b0;
            ifid_tgt_q   <= '0;
            redir_cnt_q  <= '0;
        end else begin
            pc_q <= pc_d;
            if (Exception || ExRedirect) begin
                ifid_instr_q <= '0;
                ifid_pc4_q   <= '0;
                ifid_valid_q <= 1'b0;
                ifid_pt_q    <= 1'b0;
                ifid_tgt_q   <= '0;
            end else if (!Stall) begin
                ifid_instr_q <= IMemData;
                ifid_pc4_q   <= w_pc4;
                ifid_valid_q <= 1'b1;
                ifid_pt_q    <= w_pred_taken;
                ifid_tgt_q   <= w_pred_taken ? btb_tgt_q[w_lk_idx] : 32'd0;
            end
            if (ExRedirect && (redir_cnt_q != 32'hFFFFFFFF))
                redir_cnt_q <= redir_cnt_q + 32'd1;
        end
    end

    // BTB training is independent of stalls and flushes
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
                btb_cnt_q[i]   <= 2'b01;
            end
        end else if (ExBranchValid) begin
            if (w_up_hit) begin
                if (ExBranchTaken) begin
                    if (btb_cnt_q[w_up_idx] != 2'b11)
                        btb_cnt_q[w_up_idx] <= btb_cnt_q[w_up_idx] + 2'b01;
                    btb_tgt_q[w_up_idx] <= ExBranchTarget;
                end else if (btb_cnt_q[w_up_idx] != 2'b00) begin
                    btb_cnt_q[w_up_idx] <= btb_cnt_q[w_up_idx] - 2'b01;
                end
            end else if (ExBranchTaken) begin
                btb_valid_q[w_up_idx] <= 1'b1;
                btb_tag_q[w_up_idx]   <= w_up_tag;
                btb_tgt_q[w_up_idx]   <= ExBranchTarget;
                btb_cnt_q[w_up_idx]   <= 2'b10;
            end
        end
    end

    assign IMemAddress      = pc_q;
    assign IFID_Instruction = ifid_instr_q;
    assign IFID_PC4         = ifid_pc4_q;
    assign IFID_Valid       = ifid_valid_q;
    assign IFID_PredTaken   = ifid_pt_q;
    assign IFID_PredTarget  = ifid_tgt_q;
    assign RedirectCount    = redir_cnt_q;

endmodule
`default_nettype wire
